// File: rtl/resta_pf_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = A - B).
// The unit runs as an effective add of A and -B. It processes one bit per cycle in the align and normalize steps.
module resta_pf_seq #(
   parameter int unsigned MAX_ALIGN = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_UNPACK = 3'd1;
   localparam logic [2:0] S_ALIGN  = 3'd2;
   localparam logic [2:0] S_ADDSUB = 3'd3;
   localparam logic [2:0] S_NORM   = 3'd4;
   localparam logic [2:0] S_ROUND  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [7:0] MAXA = 8'(MAX_ALIGN);

   logic [2:0]  state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] result_q, result_d;
   logic        sx_q, sx_d, sub_q, sub_d, big_q, big_d;
   logic [9:0]  ex_q, ex_d;
   logic [23:0] xs_q, xs_d;
   logic [26:0] ys_q, ys_d;   // {significand, guard, round, sticky}
   logic [7:0]  cnt_q, cnt_d;
   logic [27:0] m_q, m_d;     // {carry, significand, guard, round, sticky}

   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;
   logic [31:0] x_op, y_op;
   logic [7:0]  diff;
   logic [26:0] ys_sh;
   logic [27:0] sum;
   logic [24:0] r25;
   logic        rnd;
   logic [9:0]  e_rnd;

   assign a_zero = (a_q[30:23] == 8'h00);
   assign b_zero = (b_q[30:23] == 8'h00);
   assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
   assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
   assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
   assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
   assign a_ge   = (a_q[30:0] >= b_q[30:0]);
   assign x_op   = a_ge ? a_q : b_q;
   assign y_op   = a_ge ? b_q : a_q;
   assign diff   = x_op[30:23] - y_op[30:23];
   assign ys_sh  = {1'b0, ys_q[26:2], ys_q[1] | ys_q[0]};
   assign sum    = sub_q ? ({1'b0, xs_q, 3'b000} - {1'b0, ys_q})
                         : ({1'b0, xs_q, 3'b000} + {1'b0, ys_q});
   assign rnd    = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
   assign r25    = {1'b0, m_q[26:3]} + 25'(rnd);
   assign e_rnd  = ex_q + 10'(r25[24]);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      sx_d     = sx_q;
      sub_d    = sub_q;
      big_d    = big_q;
      ex_d     = ex_q;
      xs_d     = xs_q;
      ys_d     = ys_q;
      cnt_d    = cnt_q;
      m_d      = m_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = {~B[31], B[30:0]};
               state_d = S_UNPACK;
            end
         end
         S_UNPACK: begin
            // b_q already carries the inverted sign, so B-side results need no extra negation
            state_d = S_DONE;
            if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31])))
               result_d = 32'h7FC0_0000;
            else if (a_inf)
               result_d = a_q;
            else if (b_inf)
               result_d = b_q;
            else if (a_zero && b_zero)
               result_d = {a_q[31] & b_q[31], 31'h0};
            else if (a_zero)
               result_d = b_q;
            else if (b_zero)
               result_d = a_q;
            else begin
               sx_d    = x_op[31];
               sub_d   = x_op[31] ^ y_op[31];
               ex_d    = {2'b00, x_op[30:23]};
               xs_d    = {1'b1, x_op[22:0]};
               ys_d    = {1'b1, y_op[22:0], 3'b000};
               big_d   = (diff > MAXA);
               cnt_d   = (diff > MAXA) ? MAXA : diff;
               state_d = (diff == 8'h00) ? S_ADDSUB : S_ALIGN;
            end
         end
         S_ALIGN: begin
            ys_d  = ys_sh;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
               if (big_q) ys_d = {26'h0, |ys_sh};
               state_d = S_ADDSUB;
            end
         end
         S_ADDSUB: begin
            m_d = sum;
            if (sum == 28'h0) begin
               result_d = '0;
               state_d  = S_DONE;
            end else if (sum[27] || !sum[26])
               state_d = S_NORM;
            else
               state_d = S_ROUND;
         end
         S_NORM: begin
            if (m_q[27]) begin
               m_d     = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
               ex_d    = ex_q + 10'd1;
               state_d = S_ROUND;
            end else begin
               m_d  = {m_q[26:0], 1'b0};
               ex_d = ex_q - 10'd1;
               if (ex_q == 10'd1) begin
                  result_d = {sx_q, 31'h0};
                  state_d  = S_DONE;
               end else if (m_q[25])
                  state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            if (e_rnd >= 10'd255)
               result_d = {sx_q, 8'hFF, 23'h0};
            else
               result_d = {sx_q, e_rnd[7:0], r25[24] ? r25[23:1] : r25[22:0]};
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         sx_q     <= 1'b0;
         sub_q    <= 1'b0;
         big_q    <= 1'b0;
         ex_q     <= '0;
         xs_q     <= '0;
         ys_q     <= '0;
         cnt_q    <= '0;
         m_q      <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         sx_q     <= sx_d;
         sub_q    <= sub_d;
         big_q    <= big_d;
         ex_q     <= ex_d;
         xs_q     <= xs_d;
         ys_q     <= ys_d;
         cnt_q    <= cnt_d;
         m_q      <= m_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_resta_pf_seq.sv
// Scoreboard bench for resta_pf_seq: directed vectors with hand-computed results and done latency.
module tb_resta_pf_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   resta_pf_seq #(.MAX_ALIGN(26)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %08h expected %08h", name, act, req);
   endtask

   // Monitor: every done pulse pops one expectation and checks value and cycle.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done at cycle %0d result %08h", cyc, result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input string name);
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      sb.push_back('{res, cyc + lat, name});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'h0);

      // 3.0 - 1.0: busy from cycle 1, done cycle 5, idle afterwards
      issue(32'h40400000, 32'h3F800000, 32'h40000000, 5, "three_minus_one");
      chk("busy_cycle1", 32'(busy), 32'd1);
      wait_done();
      chk("busy_after_done", 32'(busy), 32'd0);

      issue(32'h3F800000, 32'hBF800000, 32'h40000000, 5, "carry_out");           wait_done();
      issue(32'h3F800000, 32'h3F800000, 32'h00000000, 3, "exact_zero");          wait_done();
      issue(32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 29, "borrow_norm");        wait_done();
      issue(32'h7F800000, 32'h7F800000, 32'h7FC00000, 2, "inf_minus_inf");      wait_done();
      issue(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5, "overflow");           wait_done();
      issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, "nan_in");             wait_done();
      issue(32'h7F800000, 32'hFF800000, 32'h7F800000, 2, "inf_plus_inf");       wait_done();
      issue(32'h3F800000, 32'hFF800000, 32'h7F800000, 2, "b_inf_negated");      wait_done();
      issue(32'h00000000, 32'h3F800000, 32'hBF800000, 2, "a_zero_pass");        wait_done();
      issue(32'h80000000, 32'h00000000, 32'h80000000, 2, "neg_zero");           wait_done();
      issue(32'h00000000, 32'h00000000, 32'h00000000, 2, "pos_zero");           wait_done();
      issue(32'h4F800000, 32'h3F800000, 32'h4F800000, 31, "sticky_only_round"); wait_done();
      issue(32'h3F800000, 32'hB3800000, 32'h3F800000, 28, "tie_even_down");     wait_done();
      issue(32'h3F800001, 32'hB3800000, 32'h3F800002, 28, "tie_odd_up");        wait_done();
      issue(32'h00800000, 32'h00C00000, 32'h80000000, 4, "underflow_flush");    wait_done();

      // start and A changed while busy must be ignored
      issue(32'h40400000, 32'h3F800000, 32'h40000000, 5, "ignore_start");
      start = 1'b1;
      A = 32'h12345678;
      B = 32'h7F800000;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // reset during ALIGN aborts silently
      @(negedge clk);
      A = 32'h4F800000;
      B = 32'h3F800000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", result, 32'h0);
      repeat (40) @(negedge clk);

      issue(32'h40400000, 32'h3F800000, 32'h40000000, 5, "after_abort");
      wait_done();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/resta_pf_seq.md
Name: resta_pf_seq

Overview:
Multi-cycle IEEE-754 single-precision subtractor computing result = A - B, the subtract-direction counterpart of the team's floating-point adder. Operands are captured on a start handshake. A state machine then unpacks, aligns, subtracts, normalizes and rounds the operands, and reports completion with a one-cycle done pulse. It sits beside the adder in the FP datapath and shares its field split: sign [31], exponent [30:23], mantissa [22:0].

Parameters:
MAX_ALIGN, 26, cap on alignment right-shift cycles; larger exponent differences fold fully into sticky.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  32  minuend, IEEE-754 single
B  input  32  subtrahend, IEEE-754 single
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when result is valid
result  output  32  A - B; held stable from done until next accepted start

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, result=32'h0. Reset mid-operation aborts the operation; no done pulse is produced.
- Capture: in IDLE with start=1, A and B are registered. B's sign is inverted, making the operation an effective add of A and -B. start in any other state is ignored, and A/B changes after capture have no effect.
- States: IDLE -> UNPACK -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE -> IDLE.
- UNPACK (1 cycle):
  - exp==0 operands are flushed to signed zero (no denormal support); hidden bit is 1 for nonzero operands.
  - Specials go straight to DONE:
    - any NaN -> 32'h7FC00000;
    - inf - inf of equal signs -> 32'h7FC00000;
    - otherwise an inf operand -> that inf, with B's sign inverted if it came from B;
    - both operands zero -> +0, or -0 only if A=-0 and B=+0.
  - One zero operand: the other operand is passed through (B negated) via DONE.
  - Otherwise the larger-magnitude operand becomes X, the other Y, and d = expX - expY.
- ALIGN (k = min(d, MAX_ALIGN) cycles; 0 cycles means the state is skipped):
  - Y's 24-bit significand, extended with guard/round/sticky bits, shifts right 1 bit per cycle.
  - Bits shifted out OR into sticky.
  - If d > MAX_ALIGN, Y becomes sticky-only.
- ADDSUB (1 cycle): 28-bit magnitude add when signs are equal (after B inversion), else X - Y. Result sign = sign of X. An exact zero difference gives +0 and goes to DONE.
- NORM (n cycles, 1 bit per cycle):
  - On carry-out: one right shift, exp+1, sticky preserved.
  - Else: left shifts until bit 23 (hidden) = 1, exp-1 per shift.
  - If exp reaches 0 while shifting, the result is flushed to signed zero -> DONE.
- ROUND (1 cycle):
  - Round-to-nearest-even using guard, round and sticky bits.
  - Mantissa overflow renormalizes: exp+1.
  - exp >= 255 -> signed inf (exp=8'hFF, mantissa 0).
- DONE (1 cycle): result is registered, done=1, busy=1. Next state is IDLE, with busy=0 and done=0.
- Latency: start cycle = 0; done high in cycle 4+k+n. Specials and zero-operand bypasses give done in cycle 2. A new start is accepted no earlier than the cycle after done.

Test Plan:
- A=32'h40400000 (3.0), B=32'h3F800000 (1.0), start 1 cycle -> k=1, n=0; done in cycle 5; result=32'h40000000; busy high cycles 1-5.
- A=32'h3F800000, B=32'hBF800000 (1.0 - -1.0) -> carry-out, n=1; done in cycle 5; result=32'h40000000.
- A=32'h3F800000, B=32'h3F800000 -> result=32'h00000000 (+0); A=32'h3F800000, B=32'h33800000 -> result=32'h3F7FFFFF (borrow, left-normalize, exact).
- A=32'h7F800000, B=32'h7F800000 -> result=32'h7FC00000, done in cycle 2; A=32'h7F7FFFFF, B=32'hFF7FFFFF -> result=32'h7F800000 (overflow).
- Start re-asserted and A changed while busy -> ignored, original result returned. rst pulsed in ALIGN -> busy=0, done never pulses, result=0; next start proceeds normally.
